// File: rtl/inst_mem_pipe.sv
// Clocked instruction memory for the fetch stage: registered 1-cycle read with handshake,
// stall hold, conflict bubbles, runtime program-load port and post-reset clear sequence.
module inst_mem_pipe #(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DEPTH    = 64,
  parameter int unsigned       PC_SHIFT = 0,
  parameter logic [DATA_W-1:0] NOP_WORD = 16'h0800
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fetch_req_i,
  input  logic [ADDR_W-1:0] fetch_pc_i,
  output logic              fetch_ready_o,
  input  logic              fetch_stall_i,
  input  logic              mem_conflict_i,
  output logic [DATA_W-1:0] instr_out_o,
  output logic              instr_valid_o,
  output logic              instr_oob_o,
  input  logic              load_en_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic              load_ack_o,
  output logic              init_done_o
);

  localparam int unsigned       IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DepthExt = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              oob_q, oob_d;
  logic              ack_q, ack_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [IdxW-1:0]   mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [ADDR_W-1:0] fetch_idx;
  logic              fetch_in_range;
  logic              load_in_range;
  logic              hold;

  // Full-width compares: no modulo wrap of large addresses into the array.
  assign fetch_idx      = fetch_pc_i >> PC_SHIFT;
  assign fetch_in_range = {1'b0, fetch_idx} < DepthExt;
  assign load_in_range  = {1'b0, load_addr_i} < DepthExt;
  assign hold           = valid_q & fetch_stall_i;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: INIT walks every word exactly once, then RUN forever
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == StInit) begin
      cnt_d = cnt_q + IdxW'(1);
      if (cnt_q == IdxW'(DEPTH - 1)) begin
        state_d = StRun;
        cnt_d   = '0;
      end
    end
  end

  // Output / datapath logic; priority hold > load > conflict > fetch
  always_comb begin
    fetch_ready_o = 1'b0;
    instr_d       = NOP_WORD;
    valid_d       = 1'b0;
    oob_d         = 1'b0;
    ack_d         = 1'b0;
    done_d        = (state_d == StRun);
    mem_we        = 1'b0;
    mem_waddr     = cnt_q;
    mem_wdata     = NOP_WORD;
    unique case (state_q)
      StInit: mem_we = 1'b1;
      StRun: begin
        fetch_ready_o = ~load_en_i & ~mem_conflict_i & ~hold;
        if (hold) begin
          instr_d = instr_q;
          valid_d = valid_q;
          oob_d   = oob_q;
        end else if (load_en_i) begin
          ack_d     = 1'b1;
          mem_we    = load_in_range;
          mem_waddr = load_addr_i[IdxW-1:0];
          mem_wdata = load_data_i;
        end else if (fetch_req_i && !mem_conflict_i) begin
          valid_d = 1'b1;
          if (fetch_in_range) begin
            instr_d = mem_q[fetch_idx[IdxW-1:0]];
          end else begin
            oob_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      oob_q   <= 1'b0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      instr_q <= instr_d;
      valid_q <= valid_d;
      oob_q   <= oob_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
    end
  end

  // No reset on the array so it maps onto RAM; INIT defines its contents.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign instr_out_o   = instr_q;
  assign instr_valid_o = valid_q;
  assign instr_oob_o   = oob_q;
  assign load_ack_o    = ack_q;
  assign init_done_o   = done_q;

endmodule

// File: tb/tb_inst_mem_pipe.sv
// Self-checking bench for inst_mem_pipe: cycle model plus fetch scoreboard, table-driven
// readback vectors and directed stall / conflict / out-of-range / reset sequences.
module tb_inst_mem_pipe;

  localparam int          DEPTH = 64;
  localparam logic [15:0] NOP   = 16'h0800;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req = 1'b0;
  logic [15:0] fetch_pc = '0;
  logic        fetch_ready;
  logic        fetch_stall = 1'b0;
  logic        mem_conflict = 1'b0;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        instr_oob;
  logic        load_en = 1'b0;
  logic [15:0] load_addr = '0;
  logic [15:0] load_data = '0;
  logic        load_ack;
  logic        init_done;

  inst_mem_pipe dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .fetch_req_i   (fetch_req),
    .fetch_pc_i    (fetch_pc),
    .fetch_ready_o (fetch_ready),
    .fetch_stall_i (fetch_stall),
    .mem_conflict_i(mem_conflict),
    .instr_out_o   (instr_out),
    .instr_valid_o (instr_valid),
    .instr_oob_o   (instr_oob),
    .load_en_i     (load_en),
    .load_addr_i   (load_addr),
    .load_data_i   (load_data),
    .load_ack_o    (load_ack),
    .init_done_o   (init_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_run;
  int          m_cnt;
  logic        m_valid;
  logic        m_oob;
  logic [15:0] m_instr;
  logic [15:0] m_mem [DEPTH];

  typedef struct packed {
    logic [15:0] data;
    logic        oob;
  } sb_t;
  sb_t sb_q[$];

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] exp_data;
    logic        exp_oob;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    fetch_req    = 1'b0;
    fetch_pc     = '0;
    fetch_stall  = 1'b0;
    mem_conflict = 1'b0;
    load_en      = 1'b0;
    load_addr    = '0;
    load_data    = '0;
  endtask

  // One clock: predict from current inputs, then compare every output #1 after the edge.
  task automatic tick();
    logic hold, exp_ready, ld, acc;
    int   idx;
    sb_t  e;
    #1;
    hold      = m_valid & fetch_stall;
    exp_ready = m_run & !load_en & !mem_conflict & !hold;
    chk("fetch_ready", 32'(fetch_ready), 32'(exp_ready));
    ld  = 1'b0;
    acc = 1'b0;
    if (!m_run) begin
      m_cnt++;
      if (m_cnt == DEPTH) m_run = 1'b1;
    end else if (hold) begin
      // outputs frozen
    end else if (load_en) begin
      ld = 1'b1;
      if (int'(load_addr) < DEPTH) m_mem[load_addr[5:0]] = load_data;
      m_valid = 1'b0;
      m_instr = NOP;
      m_oob   = 1'b0;
    end else if (fetch_req && !mem_conflict) begin
      acc = 1'b1;
      idx = int'(fetch_pc);
      if (idx < DEPTH) e = '{data: m_mem[fetch_pc[5:0]], oob: 1'b0};
      else e = '{data: NOP, oob: 1'b1};
      sb_q.push_back(e);
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
      m_instr = NOP;
      m_oob   = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("init_done", 32'(init_done), 32'(m_run));
    chk("load_ack", 32'(load_ack), 32'(ld));
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    if (acc) begin
      e       = sb_q.pop_front();
      m_instr = e.data;
      m_oob   = e.oob;
    end
    chk("instr_out", 32'(instr_out), 32'(m_instr));
    chk("instr_oob", 32'(instr_oob), 32'(m_oob));
  endtask

  // Asserts rst away from the clock edge and checks outputs clear without a clock.
  task automatic assert_rst();
    #3;
    rst = 1'b1;
    #1;
    chk("rst_instr_out", 32'(instr_out), 32'(NOP));
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_oob", 32'(instr_oob), 32'd0);
    chk("rst_ack", 32'(load_ack), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_ready", 32'(fetch_ready), 32'd0);
    clear_inputs();
    @(posedge clk);
    #1;
    rst     = 1'b0;
    m_run   = 1'b0;
    m_cnt   = 0;
    m_valid = 1'b0;
    m_instr = NOP;
    m_oob   = 1'b0;
    sb_q.delete();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = NOP;
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    while (!init_done && n < 200) begin
      tick();
      n++;
    end
    chk("init_cycles", 32'(n), 32'd64);
  endtask

  task automatic fetch1(input logic [15:0] pc);
    fetch_req = 1'b1;
    fetch_pc  = pc;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] words [4];
    vec_t        vecs  [7];
    words[0] = 16'h4901;
    words[1] = 16'h4101;
    words[2] = 16'h6302;
    words[3] = 16'hE129;
    vecs[0]  = '{pc: 16'd0,     exp_data: 16'h4901, exp_oob: 1'b0};
    vecs[1]  = '{pc: 16'd1,     exp_data: 16'h4101, exp_oob: 1'b0};
    vecs[2]  = '{pc: 16'd2,     exp_data: 16'h6302, exp_oob: 1'b0};
    vecs[3]  = '{pc: 16'd3,     exp_data: 16'hE129, exp_oob: 1'b0};
    vecs[4]  = '{pc: 16'd64,    exp_data: 16'h0800, exp_oob: 1'b1};
    vecs[5]  = '{pc: 16'hFFFF,  exp_data: 16'h0800, exp_oob: 1'b1};
    vecs[6]  = '{pc: 16'd63,    exp_data: 16'h0800, exp_oob: 1'b0};

    // T1: reset, INIT length, fetch of a cleared word
    assert_rst();
    wait_init();
    tick();
    fetch1(16'd5);
    chk("t1_instr", 32'(instr_out), 32'h0800);
    chk("t1_valid", 32'(instr_valid), 32'd1);
    chk("t1_oob", 32'(instr_oob), 32'd0);
    clear_inputs();
    tick();

    // T2: load burst, one ack per load, then table-driven back-to-back readback
    for (int i = 0; i < 4; i++) begin
      load_en   = 1'b1;
      load_addr = 16'(i);
      load_data = words[i];
      tick();
      chk("t2_ack", 32'(load_ack), 32'd1);
    end
    clear_inputs();
    tick();
    chk("t2_ack_drop", 32'(load_ack), 32'd0);
    for (int i = 0; i < 7; i++) begin
      fetch1(vecs[i].pc);
      chk("vec_data", 32'(instr_out), 32'(vecs[i].exp_data));
      chk("vec_oob", 32'(instr_oob), 32'(vecs[i].exp_oob));
      chk("vec_valid", 32'(instr_valid), 32'd1);
    end
    clear_inputs();
    tick();

    // T3: downstream stall holds the word and blocks the next request
    fetch1(16'd1);
    fetch_stall = 1'b1;
    fetch_pc    = 16'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_hold", 32'(instr_out), 32'h4101);
      chk("t3_ready", 32'(fetch_ready), 32'd0);
    end
    fetch_stall = 1'b0;
    tick();
    chk("t3_next", 32'(instr_out), 32'h6302);
    clear_inputs();
    tick();

    // T4: memory conflict bubbles without dropping the request
    fetch_req    = 1'b1;
    fetch_pc     = 16'd3;
    mem_conflict = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t4_bubble", 32'(instr_valid), 32'd0);
    end
    mem_conflict = 1'b0;
    tick();
    chk("t4_data", 32'(instr_out), 32'hE129);
    chk("t4_valid", 32'(instr_valid), 32'd1);
    clear_inputs();
    tick();

    // T5: out-of-range load is acked but leaves the array untouched
    load_en   = 1'b1;
    load_addr = 16'd70;
    load_data = 16'h1234;
    tick();
    chk("t5_ack", 32'(load_ack), 32'd1);
    clear_inputs();
    fetch1(16'd6);
    chk("t5_pc6", 32'(instr_out), 32'h0800);
    fetch1(16'd70);
    chk("t5_pc70_oob", 32'(instr_oob), 32'd1);
    clear_inputs();
    tick();

    // T6: reset during a load burst, then again mid-INIT; loads must be wiped
    load_en   = 1'b1;
    load_addr = 16'd10;
    load_data = 16'hAAAA;
    tick();
    load_addr = 16'd11;
    load_data = 16'hBBBB;
    tick();
    assert_rst();
    for (int i = 0; i < 10; i++) tick();
    assert_rst();
    wait_init();
    for (int i = 0; i < 4; i++) begin
      fetch1(16'(i));
      chk("t6_cleared", 32'(instr_out), 32'h0800);
    end
    fetch1(16'd10);
    chk("t6_cleared10", 32'(instr_out), 32'h0800);
    fetch1(16'd11);
    chk("t6_cleared11", 32'(instr_out), 32'h0800);
    clear_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
